// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D memory arbiter: FSM states, port select, command word.
package mem_arbiter_pkg;

  localparam int XLEN      = 32;
  localparam int RD_CTRL_W = 3;
  localparam int WR_CTRL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } arb_port_e;

  typedef struct packed {
    arb_port_e            port;
    logic                 we;
    logic [XLEN-1:0]      addr;
    logic [XLEN-1:0]      wdata;
    logic [RD_CTRL_W-1:0] rd_ctrl;
    logic [WR_CTRL_W-1:0] wr_ctrl;
  } arb_cmd_t;

  // Counter width able to hold limit-1; never narrower than one bit.
  function automatic int cnt_width(input int lim);
    return (lim < 2) ? 1 : $clog2(lim);
  endfunction

endpackage

// File: rtl/mem_arbiter_timeout_cnt.sv
// Busy-cycle counter: expired is high while the count sits at limit-1 (limit=0 never expires).
module arb_timeout_cnt #(
  parameter int CW = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clr,
  input  logic      en,
  input  logic [CW:0] limit,
  output logic      expired
);

  logic [CW-1:0] cnt;
  logic [CW:0]   last;

  assign last    = limit - 1'b1;
  assign expired = (limit != '0) && ({1'b0, cnt} == last);

  // Holding at the limit keeps the count from wrapping if the caller lingers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (clr)            cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one single-port memory with timeout.
// ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests; otherwise data port wins.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [XLEN-1:0]      if_addr,
  output logic                 if_ack,
  output logic [XLEN-1:0]      if_rdata,
  output logic                 if_err,
  input  logic                 dm_req,
  input  logic                 dm_we,
  input  logic [XLEN-1:0]      dm_addr,
  input  logic [XLEN-1:0]      dm_wdata,
  input  logic [RD_CTRL_W-1:0] dm_rd_ctrl,
  input  logic [WR_CTRL_W-1:0] dm_wr_ctrl,
  output logic                 dm_ack,
  output logic [XLEN-1:0]      dm_rdata,
  output logic                 dm_err,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  output logic [RD_CTRL_W-1:0] mem_rd_ctrl,
  output logic [WR_CTRL_W-1:0] mem_wr_ctrl,
  input  logic [XLEN-1:0]      mem_rdata,
  input  logic                 mem_ready
);

  localparam int          CW    = cnt_width(TIMEOUT_CYC);
  localparam logic [CW:0] LIMIT = TIMEOUT_CYC[CW:0];

  arb_state_e      state_q, state_d;
  arb_cmd_t        cmd_q, cmd_nxt;
  arb_port_e       grant;
  logic            grant_any;
  logic            busy, expired, tmo, done;
  logic            err_q;
  logic [XLEN-1:0] if_rdata_q, dm_rdata_q;

`ifdef ARB_ROUND_ROBIN_EN
  arb_port_e last_q;

  always_comb begin
    if (if_req && dm_req) grant = (last_q == PORT_D) ? PORT_I : PORT_D;
    else                  grant = dm_req ? PORT_D : PORT_I;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 last_q <= PORT_D;
    else if (state_q == ST_IDLE && grant_any) last_q <= grant;
  end
`else
  always_comb grant = dm_req ? PORT_D : PORT_I;
`endif

  assign grant_any = if_req | dm_req;
  assign busy      = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);
  // Ready on the limit cycle wins over the timeout.
  assign tmo       = busy && !mem_ready && expired;
  assign done      = busy && (mem_ready || tmo);

  arb_timeout_cnt #(.CW(CW)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (!busy),
    .en      (busy && !mem_ready),
    .limit   (LIMIT),
    .expired (expired)
  );

  // Fetches carry no store or sizing info; the ctrl fields go out as zero.
  always_comb begin
    cmd_nxt = '0;
    cmd_nxt.port = grant;
    if (grant == PORT_D) begin
      cmd_nxt.we      = dm_we;
      cmd_nxt.addr    = dm_addr;
      cmd_nxt.wdata   = dm_wdata;
      cmd_nxt.rd_ctrl = dm_rd_ctrl;
      cmd_nxt.wr_ctrl = dm_wr_ctrl;
    end else begin
      cmd_nxt.addr    = if_addr;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant_any) state_d = (grant == PORT_D) ? ST_BUSY_D : ST_BUSY_I;
      ST_BUSY_I,
      ST_BUSY_D: if (done) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && grant_any) cmd_q <= cmd_nxt;
      if (done) begin
        err_q <= tmo;
        if (cmd_q.port == PORT_I)  if_rdata_q <= tmo ? '0 : mem_rdata;
        else if (!cmd_q.we)        dm_rdata_q <= tmo ? '0 : mem_rdata;
      end
    end
  end

  assign mem_req     = busy;
  assign mem_we      = cmd_q.we;
  assign mem_addr    = cmd_q.addr;
  assign mem_wdata   = cmd_q.wdata;
  assign mem_rd_ctrl = cmd_q.rd_ctrl;
  assign mem_wr_ctrl = cmd_q.wr_ctrl;

  assign if_ack   = (state_q == ST_RESP) && (cmd_q.port == PORT_I);
  assign dm_ack   = (state_q == ST_RESP) && (cmd_q.port == PORT_D);
  assign if_err   = if_ack && err_q;
  assign dm_err   = dm_ack && err_q;
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a small latency-programmable memory model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ack, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_ack, dm_err;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [2:0]  dm_rd_ctrl, mem_rd_ctrl;
  logic [1:0]  dm_wr_ctrl, mem_wr_ctrl;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    bit          port_d;
    logic [31:0] rdata;
    bit          err;
  } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;
  int ready_delay = 0;
  int busy_cnt = 0;
  logic        fix_en = 1'b0;
  logic [31:0] fix_val = '0;
  logic [31:0] exp_if_rdata = '0, exp_dm_rdata = '0;

  mem_arbiter #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rd_ctrl(dm_rd_ctrl), .dm_wr_ctrl(dm_wr_ctrl),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd_ctrl(mem_rd_ctrl), .mem_wr_ctrl(mem_wr_ctrl),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Memory answers on busy cycle index ready_delay (0 = first); negative never answers.
  always @(posedge clk) busy_cnt <= mem_req ? busy_cnt + 1 : 0;
  assign mem_ready = mem_req && (ready_delay >= 0) && (busy_cnt == ready_delay);
  assign mem_rdata = fix_en ? fix_val : (mem_addr ^ 32'hA5A5_0000);

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    vectors++; if ({if_ack, dm_ack, if_err, dm_err} !== 4'b0) begin miscompares++; $display("FAIL rst_ack_err: got %b want 0000", {if_ack, dm_ack, if_err, dm_err}); end
    vectors++; if ({if_rdata, dm_rdata} !== 64'h0) begin miscompares++; $display("FAIL rst_rdata: got %h want 0", {if_rdata, dm_rdata}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    exp_t e;
    fix_en = 1'b1; fix_val = 32'h00A0_0093; ready_delay = 0;
    if_req = 1'b1; if_addr = 32'h40;
    sb.push_back('{1'b0, 32'h00A0_0093, 1'b0});
    exp_if_rdata = 32'h00A0_0093;
    tick();
    vectors++; if ({mem_req, mem_we, mem_addr, if_ack} !== {1'b1, 1'b0, 32'h40, 1'b0}) begin
      miscompares++; $display("FAIL fetch_cmd: got req=%b we=%b addr=%h ack=%b want 1 0 00000040 0", mem_req, mem_we, mem_addr, if_ack); end
    tick();
    e = sb.pop_front();
    vectors++; if ({if_ack, dm_ack} !== {!e.port_d, e.port_d}) begin miscompares++; $display("FAIL fetch_ack: got if=%b dm=%b want 1 0", if_ack, dm_ack); end
    vectors++; if ({if_rdata, if_err} !== {e.rdata, e.err}) begin miscompares++; $display("FAIL fetch_data: got %h err=%b want %h err=%b", if_rdata, if_err, e.rdata, e.err); end
    if_req = 1'b0;
    tick();
    vectors++; if ({if_ack, mem_req, if_rdata} !== {2'b00, exp_if_rdata}) begin
      miscompares++; $display("FAIL fetch_after: got ack=%b req=%b rdata=%h want 0 0 %h", if_ack, mem_req, if_rdata, exp_if_rdata); end
    fix_en = 1'b0;
  endtask

  task automatic test_load();
    exp_t e;
    ready_delay = 1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; dm_rd_ctrl = 3'b101; dm_wr_ctrl = 2'd0;
    exp_dm_rdata = mdata(32'h200);
    sb.push_back('{1'b1, exp_dm_rdata, 1'b0});
    tick();
    vectors++; if ({mem_we, mem_rd_ctrl} !== {1'b0, 3'b101}) begin miscompares++; $display("FAIL load_ctrl: got we=%b rd=%b want 0 101", mem_we, mem_rd_ctrl); end
    for (int i = 0; i < 20 && !(if_ack || dm_ack); i++) tick();
    vectors++;
    if (!(if_ack || dm_ack)) begin miscompares++; $display("FAIL load_ack: none within 20 cycles"); end
    else begin
      e = sb.pop_front();
      if ({dm_ack, dm_rdata, dm_err} !== {e.port_d, e.rdata, e.err}) begin
        miscompares++; $display("FAIL load_data: got ack=%b %h err=%b want 1 %h 0", dm_ack, dm_rdata, dm_err, e.rdata); end
    end
    vectors++; if (if_rdata !== exp_if_rdata) begin miscompares++; $display("FAIL load_if_hold: got %h want %h", if_rdata, exp_if_rdata); end
    dm_req = 1'b0;
    tick();
  endtask

  task automatic test_store();
    exp_t e;
    bit   bad;
    ready_delay = 3;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_wr_ctrl = 2'd2; dm_rd_ctrl = 3'b000;
    sb.push_back('{1'b1, exp_dm_rdata, 1'b0});
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wr_ctrl, dm_ack} !== {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 2'd2, 1'b0}) begin
        bad = 1'b1; $display("FAIL store_cmd_c%0d: got req=%b we=%b addr=%h wd=%h wr=%0d ack=%b", c, mem_req, mem_we, mem_addr, mem_wdata, mem_wr_ctrl, dm_ack);
      end
    end
    vectors++; if (bad) miscompares++;
    tick();
    e = sb.pop_front();
    vectors++; if ({dm_ack, dm_err} !== {e.port_d, e.err}) begin miscompares++; $display("FAIL store_ack: got ack=%b err=%b want 1 0", dm_ack, dm_err); end
    vectors++; if (dm_rdata !== e.rdata) begin miscompares++; $display("FAIL store_rdata_hold: got %h want %h", dm_rdata, e.rdata); end
    dm_req = 1'b0; dm_we = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    bit bad;
    ready_delay = -1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    exp_dm_rdata = '0;
    bad = 1'b0;
    for (int c = 0; c < TMO; c++) begin
      tick();
      if ({mem_req, dm_ack} !== 2'b10) begin bad = 1'b1; $display("FAIL tmo_busy_c%0d: got req=%b ack=%b want 1 0", c, mem_req, dm_ack); end
    end
    vectors++; if (bad) miscompares++;
    tick();
    vectors++; if ({mem_req, dm_ack, dm_err, dm_rdata} !== {3'b011, exp_dm_rdata}) begin
      miscompares++; $display("FAIL tmo_resp: got req=%b ack=%b err=%b rdata=%h want 0 1 1 0", mem_req, dm_ack, dm_err, dm_rdata); end
    dm_req = 1'b0;
    tick();
    vectors++; if ({mem_req, dm_ack, dm_err} !== 3'b000) begin miscompares++; $display("FAIL tmo_after: got %b want 000", {mem_req, dm_ack, dm_err}); end
  endtask

  // Ready lands on the limit cycle; request is also dropped early and must not abort.
  task automatic test_limit_ready();
    bit bad;
    ready_delay = TMO - 1;
    if_req = 1'b1; if_addr = 32'h80;
    exp_if_rdata = mdata(32'h80);
    tick();
    if_req = 1'b0;
    bad = (mem_req !== 1'b1);
    for (int c = 1; c < TMO; c++) begin
      tick();
      if ({mem_req, if_ack} !== 2'b10) bad = 1'b1;
    end
    vectors++; if (bad) begin miscompares++; $display("FAIL limit_busy: transaction not held for %0d cycles", TMO); end
    tick();
    vectors++; if ({if_ack, if_err, if_rdata} !== {2'b10, exp_if_rdata}) begin
      miscompares++; $display("FAIL limit_resp: got ack=%b err=%b rdata=%h want 1 0 %h", if_ack, if_err, if_rdata, exp_if_rdata); end
    vectors++; if (dm_rdata !== exp_dm_rdata) begin miscompares++; $display("FAIL limit_dm_hold: got %h want %h", dm_rdata, exp_dm_rdata); end
    tick();
    vectors++; if ({if_ack, mem_req} !== 2'b00) begin miscompares++; $display("FAIL limit_after: got ack=%b req=%b want 0 0", if_ack, mem_req); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   seen;
    ready_delay = -1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h208;
    tick();
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rmid_busy: got req=%b want 1", mem_req); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rmid_req_drop: got %b want 0", mem_req); end
    dm_req = 1'b0;
    exp_if_rdata = '0; exp_dm_rdata = '0;
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (dm_ack || if_ack || mem_req) seen = 1'b1;
    end
    vectors++; if (seen) begin miscompares++; $display("FAIL rmid_no_ack: got activity=1 want 0"); end
    ready_delay = 0;
    if_req = 1'b1; if_addr = 32'h48;
    exp_if_rdata = mdata(32'h48);
    sb.push_back('{1'b0, exp_if_rdata, 1'b0});
    for (int i = 0; i < 20 && !(if_ack || dm_ack); i++) tick();
    vectors++;
    if (!(if_ack || dm_ack)) begin miscompares++; $display("FAIL rmid_next_ack: none within 20 cycles"); end
    else begin
      e = sb.pop_front();
      if ({dm_ack, if_rdata, if_err, dm_rdata} !== {e.port_d, e.rdata, e.err, exp_dm_rdata}) begin
        miscompares++; $display("FAIL rmid_next: got dm_ack=%b %h err=%b dm=%h want 0 %h 0 %h", dm_ack, if_rdata, if_err, dm_rdata, e.rdata, exp_dm_rdata); end
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_arb();
    exp_t        e;
    int          ic, dc;
    logic [31:0] got;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    exp_if_rdata = '0; exp_dm_rdata = '0;
    ready_delay = 0;
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{1'b0, mdata(32'h400 + 32'(4*k)), 1'b0});
      sb.push_back('{1'b1, mdata(32'h500 + 32'(4*k)), 1'b0});
    end
`else
    for (int k = 0; k < 4; k++) sb.push_back('{1'b1, mdata(32'h500 + 32'(4*k)), 1'b0});
    for (int k = 0; k < 4; k++) sb.push_back('{1'b0, mdata(32'h400 + 32'(4*k)), 1'b0});
`endif
    ic = 0; dc = 0;
    if_req = 1'b1; if_addr = 32'h400;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 20 && !(if_ack || dm_ack); i++) tick();
      vectors++;
      if (!(if_ack || dm_ack)) begin
        miscompares++; $display("FAIL arb_ack_%0d: none within 20 cycles", n);
        break;
      end
      e = sb.pop_front();
      got = dm_ack ? dm_rdata : if_rdata;
      if ({dm_ack, got, if_err | dm_err} !== {e.port_d, e.rdata, e.err}) begin
        miscompares++; $display("FAIL arb_grant_%0d: got port_d=%b %h err=%b want port_d=%b %h 0", n, dm_ack, got, if_err | dm_err, e.port_d, e.rdata);
      end
      if (dm_ack) begin
        exp_dm_rdata = e.rdata; dc++;
        if (dc == 4) dm_req = 1'b0; else dm_addr = 32'h500 + 32'(4*dc);
      end else begin
        exp_if_rdata = e.rdata; ic++;
        if (ic == 4) if_req = 1'b0; else if_addr = 32'h400 + 32'(4*ic);
      end
      vectors++; if ({if_rdata, dm_rdata} !== {exp_if_rdata, exp_dm_rdata}) begin
        miscompares++; $display("FAIL arb_hold_%0d: got %h %h want %h %h", n, if_rdata, dm_rdata, exp_if_rdata, exp_dm_rdata); end
      tick();
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_rd_ctrl = '0; dm_wr_ctrl = '0;
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_timeout();
    test_limit_ready();
    test_reset_mid();
    test_arb();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
